// File: rtl/tick_sched_pkg.sv
// Shared encodings and default sizes for the tick scheduler.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    localparam int DEF_CNT_W   = 27;
    localparam int DEF_DIV     = 2**26 - 1;
    localparam int TICK_CNT_W  = 8;

endpackage

// File: rtl/period_counter.sv
// Period counter: counts 0..div_active while enabled, then wraps with a
// registered one-cycle pulse. clear forces the count to 0 and kills the pulse.
module period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_active,
    output logic [CNT_W-1:0] counter,
    output logic             wrap
);

    // Count, wrap at the divisor, and register the wrap pulse.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            counter <= '0;
            wrap    <= 1'b0;
        end else if (enable) begin
            if (counter == div_active) begin
                counter <= '0;
                wrap    <= 1'b1;
            end else begin
                counter <= counter + 1'b1;
                wrap    <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_sched.sv
// Tick scheduler: run/pause/single-step FSM around a period counter, with a
// divisor reprogramming handshake that only takes effect on period boundaries.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEF_DIV)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic                  cfg_valid,
    input  logic [CNT_W-1:0]      cfg_div,
    output logic                  cfg_ready,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_cnt,
    output logic [1:0]            state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_pending;
    logic             pending;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             hit;

    // Dropping run in RUN clears the counter on the same edge, which also
    // suppresses a wrap that would otherwise have fired there.
    assign cnt_enable = (state_q == RUN) || (state_q == STEP);
    assign cnt_clear  = (state_q == IDLE) || ((state_q == RUN) && !run);
    assign hit        = cnt_enable && !cnt_clear && (counter == div_active);

    period_counter #(.CNT_W(CNT_W)) u_period (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .div_active (div_active),
        .counter    (counter),
        .wrap       (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: run beats step in IDLE; a step returns to IDLE on its wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run)       state_d = RUN;
                else if (step) state_d = STEP;
            end
            RUN: begin
                if (!run) state_d = IDLE;
            end
            STEP: begin
                if (run)      state_d = RUN;
                else if (hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Config handshake: capture into pending, apply in IDLE or on a wrap.
    // A transfer landing on a wrap edge is not applied there because pending
    // is still clear on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= 1'b0;
            div_pending <= '0;
            div_active  <= DEFAULT_DIV;
        end else if (pending && ((state_q == IDLE) || hit)) begin
            div_active <= div_pending;
            pending    <= 1'b0;
        end else if (cfg_valid && !pending) begin
            div_pending <= cfg_div;
            pending     <= 1'b1;
        end
    end

    // Tick counter advances alongside the registered tick.
    always_ff @(posedge clk) begin
        if (reset)    tick_cnt <= '0;
        else if (hit) tick_cnt <= tick_cnt + 1'b1;
    end

    assign cfg_ready = !pending;
    assign state     = state_q;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched with CNT_W=8, DEFAULT_DIV=3. Expected tick cycles are
// queued when stimulus is driven and consumed by a tick monitor.
module tb_tick_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic       tick;
    logic [7:0] tick_cnt;
    logic [1:0] state;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int exp_q[$];

    tick_sched #(.CNT_W(8), .DEFAULT_DIV(8'd3)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .tick_cnt  (tick_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick monitor: every observed tick must match the next queued cycle.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tick_unexpected cyc=%0d got tick with empty queue", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    fails++;
                    $display("FAIL tick_time got cyc=%0d expected cyc=%0d", cyc, e);
                end
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_empty(input string name);
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL %s missing ticks: %0d still queued, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        tests++;
        if (state !== 2'b00 || tick !== 1'b0 || tick_cnt !== 8'd0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_vals got state=%b tick=%b cnt=%0d rdy=%b expected 00 0 0 1",
                     state, tick, tick_cnt, cfg_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cfg_idle(input logic [7:0] div);
        int c;
        c = cyc;
        cfg_valid = 1'b1; cfg_div = div;
        wait_to(c + 1);
        cfg_valid = 1'b0;
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++; $display("FAIL cfg_idle_accept got rdy=%b expected 0", cfg_ready);
        end
        wait_to(c + 2);
        tests++;
        if (cfg_ready !== 1'b1) begin
            fails++; $display("FAIL cfg_idle_apply got rdy=%b expected 1", cfg_ready);
        end
    endtask

    task automatic test_run();
        int c;
        c = cyc;
        run = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(c + 5 + 4*i);
        wait_to(c + 21);
        tests++;
        if (tick_cnt !== 8'd5 || state !== 2'b01) begin
            fails++; $display("FAIL run_count got cnt=%0d state=%b expected 5 01", tick_cnt, state);
        end
        run = 1'b0;
        wait_to(c + 22);
        tests++;
        if (state !== 2'b00 || tick !== 1'b0) begin
            fails++; $display("FAIL run_stop got state=%b tick=%b expected 00 0", state, tick);
        end
        wait_to(c + 26);
        check_empty("run");
    endtask

    task automatic test_step();
        int c;
        c = cyc;
        step = 1'b1;
        exp_q.push_back(c + 5);
        wait_to(c + 1); step = 1'b0;
        wait_to(c + 2); step = 1'b1;
        wait_to(c + 3); step = 1'b0;
        tests++;
        if (state !== 2'b10) begin
            fails++; $display("FAIL step_state got state=%b expected 10", state);
        end
        wait_to(c + 5);
        tests++;
        if (state !== 2'b00 || tick !== 1'b1 || tick_cnt !== 8'd6) begin
            fails++; $display("FAIL step_tick got state=%b tick=%b cnt=%0d expected 00 1 6",
                              state, tick, tick_cnt);
        end
        wait_to(c + 12);
        check_empty("step");
    endtask

    task automatic test_cfg_mid();
        int c;
        c = cyc;
        run = 1'b1;
        exp_q.push_back(c + 5); exp_q.push_back(c + 9);
        exp_q.push_back(c + 11); exp_q.push_back(c + 13); exp_q.push_back(c + 15);
        wait_to(c + 6);
        cfg_valid = 1'b1; cfg_div = 8'd1;
        wait_to(c + 7);
        cfg_valid = 1'b0;
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++; $display("FAIL cfg_mid_accept got rdy=%b expected 0", cfg_ready);
        end
        wait_to(c + 8);
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++; $display("FAIL cfg_mid_hold got rdy=%b expected 0", cfg_ready);
        end
        wait_to(c + 9);
        tests++;
        if (cfg_ready !== 1'b1) begin
            fails++; $display("FAIL cfg_mid_apply got rdy=%b expected 1", cfg_ready);
        end
        wait_to(c + 15);
        run = 1'b0;
        wait_to(c + 20);
        check_empty("cfg_mid");
    endtask

    task automatic test_cfg_wrap();
        int c;
        c = cyc;
        run = 1'b1;
        exp_q.push_back(c + 5); exp_q.push_back(c + 9); exp_q.push_back(c + 13);
        for (int i = 14; i <= 20; i++) exp_q.push_back(c + i);
        wait_to(c + 8);
        cfg_valid = 1'b1; cfg_div = 8'd0;
        wait_to(c + 9);
        cfg_valid = 1'b0;
        wait_to(c + 12);
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++; $display("FAIL cfg_wrap_hold got rdy=%b expected 0", cfg_ready);
        end
        wait_to(c + 13);
        tests++;
        if (cfg_ready !== 1'b1) begin
            fails++; $display("FAIL cfg_wrap_apply got rdy=%b expected 1", cfg_ready);
        end
        wait_to(c + 20);
        run = 1'b0;
        wait_to(c + 24);
        check_empty("cfg_wrap");
    endtask

    task automatic test_run_drop();
        int c;
        c = cyc;
        run = 1'b1;
        wait_to(c + 3);
        run = 1'b0;
        wait_to(c + 4);
        tests++;
        if (state !== 2'b00 || tick !== 1'b0) begin
            fails++; $display("FAIL drop_idle got state=%b tick=%b expected 00 0", state, tick);
        end
        wait_to(c + 6);
        run = 1'b1;
        exp_q.push_back(c + 11); exp_q.push_back(c + 15);
        wait_to(c + 15);
        run = 1'b0;
        wait_to(c + 19);
        check_empty("run_drop");
    endtask

    task automatic test_reset_mid();
        int c;
        c = cyc;
        run = 1'b1;
        wait_to(c + 3);
        cfg_valid = 1'b1; cfg_div = 8'd0;
        wait_to(c + 4);
        cfg_valid = 1'b0;
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++; $display("FAIL rst_mid_pending got rdy=%b expected 0", cfg_ready);
        end
        reset = 1'b1;
        wait_to(c + 5);
        tests++;
        if (state !== 2'b00 || tick !== 1'b0 || tick_cnt !== 8'd0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_vals got state=%b tick=%b cnt=%0d rdy=%b expected 00 0 0 1",
                     state, tick, tick_cnt, cfg_ready);
        end
        reset = 1'b0;
        exp_q.push_back(c + 10); exp_q.push_back(c + 14);
        wait_to(c + 6);
        tests++;
        if (cfg_ready !== 1'b1 || state !== 2'b01) begin
            fails++; $display("FAIL rst_mid_run got rdy=%b state=%b expected 1 01", cfg_ready, state);
        end
        wait_to(c + 14);
        run = 1'b0;
        wait_to(c + 18);
        check_empty("reset_mid");
    endtask

    task automatic test_cnt_wrap();
        int c;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        test_cfg_idle(8'd0);
        c = cyc;
        run = 1'b1;
        for (int i = 2; i <= 257; i++) exp_q.push_back(c + i);
        wait_to(c + 256);
        tests++;
        if (tick_cnt !== 8'd255) begin
            fails++; $display("FAIL cnt_255 got cnt=%0d expected 255", tick_cnt);
        end
        wait_to(c + 257);
        run = 1'b0;
        tests++;
        if (tick_cnt !== 8'd0) begin
            fails++; $display("FAIL cnt_wrap got cnt=%0d expected 0", tick_cnt);
        end
        wait_to(c + 261);
        check_empty("cnt_wrap");
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_cfg_mid();
        test_cfg_idle(8'd3);
        test_cfg_wrap();
        test_cfg_idle(8'd3);
        test_run_drop();
        test_reset_mid();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tick_sched.md
# tick_sched

Runtime-configurable tick scheduler for the slow-rate logic. It sequences a period counter on the board clock and emits single-cycle enable ticks rather than a derived clock. Software or board inputs can start, pause, single-step and reprogram it. It sits between the system clock domain and every consumer that advances at a human-visible rate (display scan, LED patterns, debounced stepping).

## Interface
Parameters:
- CNT_W, 27: width of the period counter and of cfg_div.
- DEFAULT_DIV, 2**26-1: active divisor after reset; the period is DEFAULT_DIV+1 clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- run  in  1  level; high means free-running ticks.
- step  in  1  single-cycle pulse; requests exactly one tick while paused.
- cfg_valid  in  1  new-divisor request.
- cfg_div  in  CNT_W  requested divisor N; the period is N+1 cycles.
- cfg_ready  out  1  high when no configuration is pending.
- tick  out  1  registered single-cycle enable pulse.
- tick_cnt  out  8  tick counter; wraps from 255 to 0.
- state  out  2  current state: IDLE=2'b00, RUN=2'b01, STEP=2'b10.

## Operation
- Reset values: state IDLE, counter 0, div_active DEFAULT_DIV, pending cleared, tick 0, tick_cnt 0, cfg_ready 1.
- IDLE:
  - The counter is held at 0 and no ticks are produced.
  - run=1 moves to RUN; this takes priority over step.
  - step=1 with run=0 moves to STEP.
- RUN:
  - The counter increments each cycle.
  - When counter==div_active, the counter wraps to 0 and tick is asserted.
  - run=0 moves to IDLE at the next edge, clears the counter and suppresses any tick from that edge.
  - step is ignored.
- STEP:
  - Counts exactly like RUN.
  - On the wrap edge, asserts tick and returns to IDLE.
  - run=1 during STEP moves to RUN without clearing the counter.
  - Further step pulses are ignored.
- Configuration handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_div is captured into div_pending and cfg_ready drops.
  - In IDLE, div_pending is copied to div_active at the next edge and cfg_ready rises.
  - In RUN/STEP, the copy happens at the next wrap edge, so the period after that tick uses the new value.
  - If the transfer and a wrap occur on the same edge, the value applies at the following wrap, not at this one.
  - cfg_div is unsigned; N=0 gives a tick every cycle.
- tick_cnt increments on every asserted tick and is cleared only by reset.
- Reset mid-operation discards any pending configuration and restores all reset values.

## Timing
- run=1 sampled at edge k from IDLE: tick is high in the cycles following edges k+N+1, k+2(N+1), and so on.
- step sampled at edge k in IDLE: exactly one tick, in the cycle after edge k+N+1; state reads IDLE in that same cycle.
- run=0 sampled at edge k: tick is low from the cycle after edge k onward, and state reads IDLE.
- A configuration accepted in IDLE at edge k is active for a run sampled at edge k+1 or later.
- cfg_ready is low from the accepting edge until the applying edge, inclusive of the cycles between them.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package tick_sched_pkg holds:
  - the state encodings IDLE/RUN/STEP;
  - the default CNT_W and DEFAULT_DIV constants;
  - the tick_cnt width (8).
- Sub-module period_counter:
  - inputs: clear, enable, div_active;
  - outputs: counter and a registered wrap pulse.
- tick_sched contains the FSM, the configuration handshake and tick_cnt.

## Test plan
All scenarios use CNT_W=8 and DEFAULT_DIV=3.
- Reset, then hold run=1 → the first tick 4 cycles after the run sample, then every 4 cycles; tick_cnt reaches 5 after 20 cycles.
- In IDLE, pulse step, then pulse step again 2 cycles later → exactly one tick 4 cycles after the first pulse; the second pulse is ignored; state returns to 00.
- While in RUN with N=3, transfer cfg_div=1 mid-period → cfg_ready drops; the current period completes at 4 cycles; later periods are 2 cycles; cfg_ready rises on the wrap edge.
- Transfer cfg_div=0 on the same edge as a wrap → the next period is still 4 cycles, then tick is held high continuously.
- Drop run 2 cycles into a period → no tick; state is IDLE after one edge; re-raising run restarts the full 4-cycle period.
- Assert reset mid-RUN with a configuration pending → all outputs return to reset values; the next run uses N=3 and cfg_ready is 1.
